// File: rtl/dist_pkg.sv
// Shared types and constants for the distance compensation path.
// Imported by the apply top and the saturating add/sub unit.
package dist_pkg;

    // Update sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_LATCH
    } upd_state_e;

    // Calculator request-to-result latency, in clock cycles
    localparam int SETTLE_CYC = 20;

    // Raw sentinel codes that are never compensated
    localparam logic [15:0] DIST_NONE    = 16'h0000;
    localparam logic [15:0] DIST_INVALID = 16'hFFFF;

    // Clamp limits keep results clear of the sentinels
    localparam logic [15:0] DIST_MAX = 16'hFFFE;
    localparam logic [15:0] DIST_MIN = 16'h0001;

    // Stage-1 bundle: everything stage 2 needs, frozen per sample
    typedef struct packed {
        logic [15:0] raw;
        logic [15:0] compen;
        logic        en;
    } s1_t;

endpackage

// File: rtl/dist_sat_addsub.sv
// Sign-magnitude add/subtract of a compensation onto a raw distance,
// clamped so the result never collides with the sentinel codes.
module dist_sat_addsub
    import dist_pkg::*;
#(
    parameter logic [15:0] DIST_NONE    = dist_pkg::DIST_NONE,
    parameter logic [15:0] DIST_INVALID = dist_pkg::DIST_INVALID
) (
    input  logic [15:0] raw_i,
    input  logic [15:0] compen_i,
    input  logic        en_i,
    output logic [15:0] data_o,
    output logic        sat_o
);

    logic [14:0] mag;
    logic        neg;
    logic        pass;
    logic [16:0] sum;

    assign mag  = compen_i[14:0];
    // Negative zero behaves like +0
    assign neg  = compen_i[15] && (mag != 15'd0);
    assign pass = !en_i
               || (raw_i == DIST_NONE)
               || (raw_i == DIST_INVALID);
    assign sum  = {1'b0, raw_i} + {2'b00, mag};

    // Select passthrough, clamped or plain result
    always_comb begin
        data_o = raw_i;
        sat_o  = 1'b0;
        if (pass) begin
            data_o = raw_i;
        end else if (!neg) begin
            if (sum > {1'b0, DIST_MAX}) begin
                data_o = DIST_MAX;
                sat_o  = 1'b1;
            end else begin
                data_o = sum[15:0];
            end
        end else if ({1'b0, mag} >= raw_i) begin
            data_o = DIST_MIN;
            sat_o  = 1'b1;
        end else begin
            data_o = raw_i - {1'b0, mag};
        end
    end

endmodule

// File: rtl/dist_compen_apply.sv
// Periodically refreshes the active compensation from the calculator
// and applies it to the raw distance stream in a 2-stage pipeline.
module dist_compen_apply
    import dist_pkg::*;
#(
    parameter int          SETTLE_CYC   = dist_pkg::SETTLE_CYC,
    parameter logic [15:0] DIST_NONE    = dist_pkg::DIST_NONE,
    parameter logic [15:0] DIST_INVALID = dist_pkg::DIST_INVALID
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [15:0] i_compen_period,
    output logic        o_compen_req,
    input  logic [15:0] i_dist_compen,
    input  logic        i_raw_valid,
    input  logic [15:0] i_raw_dist,
    output logic        o_dist_valid,
    output logic [15:0] o_dist_data,
    output logic        o_dist_sat
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [15:0]   per_cnt_q;
    logic          tick;

    upd_state_e    state_q;
    logic [SW-1:0] settle_q;
    logic          req_q;
    logic [15:0]   r_compen_act;

    logic          s1_vld_q;
    s1_t           s1_q;

    logic [15:0]   res_w;
    logic          sat_w;

    logic          out_vld_q;
    logic [15:0]   out_data_q;
    logic          out_sat_q;

    // Wrap on >= so a shrunk period takes effect on the next cycle
    assign tick = (i_compen_period != 16'd0)
               && (per_cnt_q >= (i_compen_period - 16'd1));

    // Free-running period counter, parked at 0 when disabled
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            per_cnt_q <= 16'd0;
        end else if (tick || (i_compen_period == 16'd0)) begin
            per_cnt_q <= 16'd0;
        end else begin
            per_cnt_q <= per_cnt_q + 16'd1;
        end
    end

    // Update sequencer: request, wait out latency, latch when quiet
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            req_q        <= 1'b0;
            r_compen_act <= 16'd0;
        end else begin
            req_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    settle_q <= '0;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYC - 1)) begin
                        state_q <= ST_LATCH;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                ST_LATCH: begin
                    // Never swap the value under an arriving sample
                    if (!i_raw_valid) begin
                        r_compen_act <= i_dist_compen;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 1: freeze raw, compensation and enable per sample
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_vld_q <= i_raw_valid;
            if (i_raw_valid) begin
                s1_q.raw    <= i_raw_dist;
                s1_q.compen <= r_compen_act;
                s1_q.en     <= i_enable;
            end
        end
    end

    dist_sat_addsub #(
        .DIST_NONE    (DIST_NONE),
        .DIST_INVALID (DIST_INVALID)
    ) u_addsub (
        .raw_i    (s1_q.raw),
        .compen_i (s1_q.compen),
        .en_i     (s1_q.en),
        .data_o   (res_w),
        .sat_o    (sat_w)
    );

    // Stage 2: register result; data holds between strobes
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= 16'd0;
            out_sat_q  <= 1'b0;
        end else begin
            out_vld_q <= s1_vld_q;
            out_sat_q <= s1_vld_q & sat_w;
            if (s1_vld_q) begin
                out_data_q <= res_w;
            end
        end
    end

    assign o_compen_req = req_q;
    assign o_dist_valid = out_vld_q;
    assign o_dist_data  = out_data_q;
    assign o_dist_sat   = out_sat_q;

endmodule

// File: tb/tb_dist_compen_apply.sv
// Directed plus randomized bench for dist_compen_apply with an
// event-level reference model of requests, latches and results.
module tb_dist_compen_apply;

    localparam int S = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] per;
    logic        req;
    logic [15:0] comp;
    logic        valid;
    logic [15:0] raw;
    logic        o_vld;
    logic [15:0] o_data;
    logic        o_sat;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_k;
    int          m_cnt;
    int          m_latch_at;
    bit          m_busy;
    bit          m_req;
    logic [15:0] m_act;
    logic [15:0] m_last;
    bit          e1_v;
    logic [15:0] e1_d;
    bit          e1_s;
    bit          eo_v;
    logic [15:0] eo_d;
    bit          eo_s;

    always #10 clk = ~clk;

    dist_compen_apply #(
        .SETTLE_CYC (S)
    ) dut (
        .i_clk_50m       (clk),
        .i_rst_n         (rst_n),
        .i_enable        (en),
        .i_compen_period (per),
        .o_compen_req    (req),
        .i_dist_compen   (comp),
        .i_raw_valid     (valid),
        .i_raw_dist      (raw),
        .o_dist_valid    (o_vld),
        .o_dist_data     (o_data),
        .o_dist_sat      (o_sat)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic void ref_calc(input logic [15:0] r,
                                     input logic [15:0] c,
                                     input bit e,
                                     output logic [15:0] d,
                                     output bit s);
        int mag;
        int sum;
        mag = int'(c & 16'h7FFF);
        d = r;
        s = 1'b0;
        if (!e || r == 16'h0000 || r == 16'hFFFF) return;
        if (c[15] == 1'b0 || mag == 0) begin
            sum = int'(r) + mag;
            if (sum > 65534) begin
                d = 16'hFFFE;
                s = 1'b1;
            end else begin
                d = 16'(sum);
            end
        end else if (mag >= int'(r)) begin
            d = 16'h0001;
            s = 1'b1;
        end else begin
            d = 16'(int'(r) - mag);
        end
    endfunction

    task automatic model_reset();
        m_k = 0;
        m_cnt = 0;
        m_latch_at = 0;
        m_busy = 0;
        m_req = 0;
        m_act = 16'd0;
        m_last = 16'd0;
        e1_v = 0;
        e1_d = 16'd0;
        e1_s = 0;
        eo_v = 0;
        eo_d = 16'd0;
        eo_s = 0;
    endtask

    // One cycle: drive, check this cycle, advance model, move on
    task automatic step(input bit v, input logic [15:0] r,
                        input bit e);
        bit tick;
        bit old_busy;
        bit req_next;
        logic [15:0] d;
        bit s;
        valid = v;
        raw = r;
        en = e;
        chk("req", req, m_req);
        chk("act", dut.r_compen_act, m_act);
        chk("vld", o_vld, eo_v);
        chk("sat", o_sat, eo_v ? eo_s : 1'b0);
        chk("data", o_data, eo_v ? eo_d : m_last);
        if (eo_v) m_last = eo_d;
        ref_calc(r, m_act, e, d, s);
        eo_v = e1_v;
        eo_d = e1_d;
        eo_s = e1_s;
        e1_v = v;
        e1_d = d;
        e1_s = s;
        tick = (per != 16'd0) && (m_cnt >= int'(per) - 1);
        old_busy = m_busy;
        req_next = tick && !old_busy;
        if (old_busy && m_k >= m_latch_at && !v) begin
            m_act = comp;
            m_busy = 0;
        end
        if (req_next) begin
            m_busy = 1;
            m_latch_at = m_k + 1 + S + 1;
        end
        m_req = req_next;
        m_cnt = (per == 16'd0 || tick) ? 0 : m_cnt + 1;
        m_k++;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] rnd_raw();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'($urandom_range(1, 300));
            3: return 16'(65535 - $urandom_range(1, 300));
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] rnd_comp();
        logic [14:0] m;
        case ($urandom_range(0, 3))
            0: m = 15'd0;
            1: m = 15'($urandom_range(1, 400));
            default: m = 15'($urandom);
        endcase
        return {1'($urandom_range(0, 1)), m};
    endfunction

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        raw = 16'd0;
        en = 1'b1;
        comp = 16'd0;
        per = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_req", req, 1'b0);
        chk("rst_vld", o_vld, 1'b0);
        chk("rst_sat", o_sat, 1'b0);
        chk("rst_data", o_data, 16'h0000);
        chk("rst_act", dut.r_compen_act, 16'h0000);

        // Add path
        per = 16'd100;
        comp = 16'h0032;
        model_reset();
        rst_n = 1'b1;
        repeat (125) step(0, 16'd0, 1);
        chk("act_add", dut.r_compen_act, 16'h0032);
        step(1, 16'd1000, 1);
        step(0, 16'd0, 1);
        chk("add_vld", o_vld, 1'b1);
        chk("add_data", o_data, 16'd1050);
        chk("add_sat", o_sat, 1'b0);

        // Subtract path
        comp = 16'h8064;
        repeat (100) step(0, 16'd0, 1);
        chk("act_sub", dut.r_compen_act, 16'h8064);
        step(1, 16'd50, 1);
        step(1, 16'd500, 1);
        chk("sub_clamp", o_data, 16'h0001);
        chk("sub_clamp_sat", o_sat, 1'b1);
        step(1, 16'h0000, 1);
        chk("sub_data", o_data, 16'd400);
        chk("sub_sat", o_sat, 1'b0);

        // Sentinels and bypass
        step(1, 16'hFFFF, 1);
        chk("none", o_data, 16'h0000);
        chk("none_sat", o_sat, 1'b0);
        step(1, 16'd1234, 0);
        chk("invalid", o_data, 16'hFFFF);
        step(0, 16'd0, 1);
        chk("bypass", o_data, 16'd1234);
        chk("bypass_sat", o_sat, 1'b0);

        // Period 64 with a continuous burst across a latch
        per = 16'd64;
        for (int i = 0; i < 300; i++) begin
            comp = rnd_comp();
            step(1, rnd_raw(), 1);
        end

        // Random traffic straddling many latches
        for (int i = 0; i < 1500; i++) begin
            comp = rnd_comp();
            step($urandom_range(0, 9) < 6, rnd_raw(),
                 $urandom_range(0, 7) != 0);
        end

        // Shrink, disable, restore the period
        per = 16'd10;
        for (int i = 0; i < 200; i++) begin
            comp = rnd_comp();
            step($urandom_range(0, 1) == 1, rnd_raw(), 1);
        end
        per = 16'd0;
        repeat (50) step(0, 16'd0, 1);
        per = 16'd64;

        // Reset mid-settle with two samples in flight
        comp = 16'h0123;
        for (int i = 0; i < 200; i++) begin
            if (m_busy && m_k > m_latch_at - S
                && m_k < m_latch_at - 4) break;
            step(0, 16'd0, 1);
        end
        chk("in_settle", m_busy && m_k < m_latch_at, 1'b1);
        comp = 16'h0456;
        step(1, 16'd777, 1);
        valid = 1'b1;
        raw = 16'd888;
        rst_n = 1'b0;
        #1;
        chk("arst_req", req, 1'b0);
        chk("arst_vld", o_vld, 1'b0);
        chk("arst_sat", o_sat, 1'b0);
        chk("arst_data", o_data, 16'h0000);
        chk("arst_act", dut.r_compen_act, 16'h0000);
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_hold_vld", o_vld, 1'b0);
        end
        model_reset();
        rst_n = 1'b1;
        repeat (64) step(0, 16'd0, 1);
        chk("first_req_64", req, 1'b1);
        repeat (30) step(0, 16'd0, 1);
        chk("act_after_rst", dut.r_compen_act, 16'h0456);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
